// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction-decode stage of a 5-stage MIPS pipeline.
//
// Holds the register file (two combinational read ports with write-back
// bypass, one synchronous write port), decodes control bits, sign-extends
// the immediate and detects load-use hazards.  All results are registered
// into the ID/EX latch.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_id_instr/npc   instruction and PC+1 from the IF/ID latch
//   wb_*              write-back port into the register file
//   flush             branch taken in MEM; squash the decode in flight
//   pc_write          0 = hold PC (stall)
//   if_id_write       0 = hold IF/ID latch (stall)
//   id_ex_*           ID/EX latch contents for the execute stage
//                     wb = {reg_write, mem_to_reg}
//                     m  = {branch, mem_read, mem_write}
//                     ex = {reg_dst, alu_op[1:0], alu_src}
//
// Stall handshake: pc_write/if_id_write act as a combinational "ready" back
// to fetch.  When low, fetch must present the same instruction again next
// cycle; the ID/EX latch takes a bubble for that cycle.  Flush overrides a
// stall so fetch can redirect immediately.
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int NUM_REGS = 32,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_id_instr,
    input  logic [WIDTH-1:0] if_id_npc,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [WIDTH-1:0] wb_write_data,
    input  logic             flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [1:0]       id_ex_wb,
    output logic [2:0]       id_ex_m,
    output logic [3:0]       id_ex_ex,
    output logic [WIDTH-1:0] id_ex_npc,
    output logic [WIDTH-1:0] id_ex_rdata1,
    output logic [WIDTH-1:0] id_ex_rdata2,
    output logic [WIDTH-1:0] id_ex_sign_ext,
    output logic [4:0]       id_ex_rt,
    output logic [4:0]       id_ex_rd,
    output logic             id_ex_valid
);

    // ---------------- field split ----------------
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign opcode = if_id_instr[31:26];
    assign rs     = if_id_instr[25:21];
    assign rt     = if_id_instr[20:16];
    assign rd     = if_id_instr[15:11];
    assign imm    = if_id_instr[15:0];

    // ---------------- register file ----------------
    logic [WIDTH-1:0] rf_q [NUM_REGS];
    logic [WIDTH-1:0] rf_d [NUM_REGS];
    logic             wb_en;
    logic [WIDTH-1:0] rdata1, rdata2;

    // Writes to r0 are dropped here so r0 never holds anything but zero.
    assign wb_en = wb_reg_write && (wb_write_reg != 5'd0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_d[i] = rf_q[i];
            if (i != 0 && wb_en && wb_write_reg == 5'(i))
                rf_d[i] = wb_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
        end
    end

    // Read ports; a write landing this cycle is forwarded (write-before-read).
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == 5'(i)) rdata1 = rf_q[i];
            if (rt == 5'(i)) rdata2 = rf_q[i];
        end
        if (wb_en && wb_write_reg == rs) rdata1 = wb_write_data;
        if (wb_en && wb_write_reg == rt) rdata2 = wb_write_data;
    end

    // ---------------- control decode ----------------
    logic [1:0] dec_wb;
    logic [2:0] dec_m;
    logic [3:0] dec_ex;
    logic       dec_known;

    always_comb begin
        dec_wb    = 2'b00;
        dec_m     = 3'b000;
        dec_ex    = 4'b0000;
        dec_known = 1'b1;
        unique case (opcode)
            6'd0: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b1100; end
            6'd35: begin dec_wb = 2'b11; dec_m = 3'b010; dec_ex = 4'b0001; end
            6'd43: begin dec_wb = 2'b00; dec_m = 3'b001; dec_ex = 4'b0001; end
            6'd4: begin dec_wb = 2'b00; dec_m = 3'b100; dec_ex = 4'b0010; end
            default: dec_known = 1'b0;
        endcase
    end

    // ---------------- hazard detection ----------------
    logic [1:0]       id_ex_wb_q,   id_ex_wb_d;
    logic [2:0]       id_ex_m_q,    id_ex_m_d;
    logic [3:0]       id_ex_ex_q,   id_ex_ex_d;
    logic [WIDTH-1:0] id_ex_npc_q,  id_ex_npc_d;
    logic [WIDTH-1:0] id_ex_rd1_q,  id_ex_rd1_d;
    logic [WIDTH-1:0] id_ex_rd2_q,  id_ex_rd2_d;
    logic [WIDTH-1:0] id_ex_sext_q, id_ex_sext_d;
    logic [4:0]       id_ex_rt_q,   id_ex_rt_d;
    logic [4:0]       id_ex_rd_q,   id_ex_rd_d;
    logic             id_ex_valid_q, id_ex_valid_d;
    logic             stall, hold, bubble;

    // A load in EX whose destination is a source here: the data is not
    // available until MEM, so insert one bubble.
    assign stall = id_ex_m_q[1] & id_ex_valid_q & (id_ex_rt_q != 5'd0) &
                   ((id_ex_rt_q == rs) | (id_ex_rt_q == rt));
    // Flush wins: fetch must be free to redirect.
    assign hold        = stall & ~flush;
    assign pc_write    = ~hold;
    assign if_id_write = ~hold;
    assign bubble      = flush | stall | ~dec_known;

    // ---------------- ID/EX latch ----------------
    always_comb begin
        // Datapath fields always follow the decode; only control is gated.
        id_ex_npc_d   = if_id_npc;
        id_ex_rd1_d   = rdata1;
        id_ex_rd2_d   = rdata2;
        id_ex_sext_d  = {{(WIDTH-16){imm[15]}}, imm};
        id_ex_rt_d    = rt;
        id_ex_rd_d    = rd;
        id_ex_wb_d    = dec_wb;
        id_ex_m_d     = dec_m;
        id_ex_ex_d    = dec_ex;
        id_ex_valid_d = 1'b1;
        if (bubble) begin
            id_ex_wb_d    = 2'b00;
            id_ex_m_d     = 3'b000;
            id_ex_ex_d    = 4'b0000;
            id_ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_wb_q    <= '0;
            id_ex_m_q     <= '0;
            id_ex_ex_q    <= '0;
            id_ex_npc_q   <= '0;
            id_ex_rd1_q   <= '0;
            id_ex_rd2_q   <= '0;
            id_ex_sext_q  <= '0;
            id_ex_rt_q    <= '0;
            id_ex_rd_q    <= '0;
            id_ex_valid_q <= 1'b0;
        end else begin
            id_ex_wb_q    <= id_ex_wb_d;
            id_ex_m_q     <= id_ex_m_d;
            id_ex_ex_q    <= id_ex_ex_d;
            id_ex_npc_q   <= id_ex_npc_d;
            id_ex_rd1_q   <= id_ex_rd1_d;
            id_ex_rd2_q   <= id_ex_rd2_d;
            id_ex_sext_q  <= id_ex_sext_d;
            id_ex_rt_q    <= id_ex_rt_d;
            id_ex_rd_q    <= id_ex_rd_d;
            id_ex_valid_q <= id_ex_valid_d;
        end
    end

    assign id_ex_wb       = id_ex_wb_q;
    assign id_ex_m        = id_ex_m_q;
    assign id_ex_ex       = id_ex_ex_q;
    assign id_ex_npc      = id_ex_npc_q;
    assign id_ex_rdata1   = id_ex_rd1_q;
    assign id_ex_rdata2   = id_ex_rd2_q;
    assign id_ex_sign_ext = id_ex_sext_q;
    assign id_ex_rt       = id_ex_rt_q;
    assign id_ex_rd       = id_ex_rd_q;
    assign id_ex_valid    = id_ex_valid_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage : directed-vector bench for id_stage with hand-computed
// expected values.
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        flush;
    logic        pc_write;
    logic        if_id_write;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rdata1;
    logic [31:0] id_ex_rdata2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic        id_ex_valid;

    int total = 0;
    int bad   = 0;

    id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_instr    (if_id_instr),
        .if_id_npc      (if_id_npc),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .flush          (flush),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_wb       (id_ex_wb),
        .id_ex_m        (id_ex_m),
        .id_ex_ex       (id_ex_ex),
        .id_ex_npc      (id_ex_npc),
        .id_ex_rdata1   (id_ex_rdata1),
        .id_ex_rdata2   (id_ex_rdata2),
        .id_ex_sign_ext (id_ex_sign_ext),
        .id_ex_rt       (id_ex_rt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_valid    (id_ex_valid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] m,
                              input logic [3:0] ex, input logic valid);
        check({tag, ".wb"},    32'(id_ex_wb),    32'(wb));
        check({tag, ".m"},     32'(id_ex_m),     32'(m));
        check({tag, ".ex"},    32'(id_ex_ex),    32'(ex));
        check({tag, ".valid"}, 32'(id_ex_valid), 32'(valid));
    endtask

    // ---------------- driver ----------------
    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc);
        if_id_instr = instr;
        if_id_npc   = npc;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_reg_write  = en;
        wb_write_reg  = r;
        wb_write_data = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive($urandom, $urandom);
            wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            flush = 1'($urandom_range(0, 1));
            tick();
        end
        check_ctrl("reset", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("reset.npc",    id_ex_npc,    32'h0);
        check("reset.rdata1", id_ex_rdata1, 32'h0);
        check("reset.sext",   id_ex_sign_ext, 32'h0);
        check("reset.rt",     32'(id_ex_rt), 32'h0);
        check("reset.pc_write",    32'(pc_write),    32'h1);
        check("reset.if_id_write", 32'(if_id_write), 32'h1);

        // release reset; read r5 (add r1,r5,r5)
        flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h00A50820, 32'h0000_0001);
        rst_n = 1'b1;
        tick();
        check("r5_after_reset.rdata1", id_ex_rdata1, 32'h0);
        check("r5_after_reset.rdata2", id_ex_rdata2, 32'h0);

        // write r3 while decoding an unknown opcode (nop)
        wb(1'b1, 5'd3, 32'hDEADBEEF);
        drive(32'hFC000000, 32'h0000_0002);
        tick();
        check_ctrl("unknown_op", 2'b00, 3'b000, 4'b0000, 1'b0);

        // add r1,r3,r3
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h00630820, 32'h0000_0003);
        tick();
        check("add.rdata1", id_ex_rdata1, 32'hDEADBEEF);
        check("add.rdata2", id_ex_rdata2, 32'hDEADBEEF);
        check("add.rd",     32'(id_ex_rd), 32'd1);
        check("add.npc",    id_ex_npc, 32'h0000_0003);
        check_ctrl("add", 2'b10, 3'b000, 4'b1100, 1'b1);

        // bypass: write r7 and read it in the same cycle (add r1,r7,r0)
        wb(1'b1, 5'd7, 32'h12345678);
        drive(32'h00E00820, 32'h0000_0004);
        tick();
        check("bypass.rdata1", id_ex_rdata1, 32'h12345678);
        check("bypass.rdata2", id_ex_rdata2, 32'h0);

        // r0: write attempt with same-cycle read, then read again
        wb(1'b1, 5'd0, 32'hFFFFFFFF);
        drive(32'h00000820, 32'h0000_0005);
        tick();
        check("r0_bypass.rdata1", id_ex_rdata1, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        check("r0_read.rdata1", id_ex_rdata1, 32'h0);
        check("r0_read.rdata2", id_ex_rdata2, 32'h0);

        // sw r5,8(r1)
        drive(32'hAC250008, 32'h0000_0006);
        tick();
        check_ctrl("sw", 2'b00, 3'b001, 4'b0001, 1'b1);
        check("sw.sext", id_ex_sign_ext, 32'h0000_0008);

        // beq r1,r2,-1
        drive(32'h1022FFFF, 32'h0000_0007);
        tick();
        check_ctrl("beq", 2'b00, 3'b100, 4'b0010, 1'b1);
        check("beq.sext", id_ex_sign_ext, 32'hFFFFFFFF);

        // lw r0,0(r1) followed by a read of r0: no hazard on r0
        drive(32'h8C200000, 32'h0000_0008);
        tick();
        drive(32'h00052020, 32'h0000_0009);
        #1;
        check("lw_r0.pc_write", 32'(pc_write), 32'h1);
        tick();
        check("lw_r0.valid", 32'(id_ex_valid), 32'h1);

        // lw r2,-4(r1), then add r4,r2,r5 -> load-use stall
        drive(32'h8C22FFFC, 32'h0000_000A);
        tick();
        check("lw.sext", id_ex_sign_ext, 32'hFFFFFFFC);
        check("lw.rt",   32'(id_ex_rt), 32'd2);
        check_ctrl("lw", 2'b11, 3'b010, 4'b0001, 1'b1);
        drive(32'h00452020, 32'h0000_000B);
        #1;
        check("load_use.pc_write",    32'(pc_write),    32'h0);
        check("load_use.if_id_write", 32'(if_id_write), 32'h0);
        tick();
        check_ctrl("load_use.bubble", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("load_use.release.pc_write",    32'(pc_write),    32'h1);
        check("load_use.release.if_id_write", 32'(if_id_write), 32'h1);
        tick();
        check_ctrl("load_use.add", 2'b10, 3'b000, 4'b1100, 1'b1);
        check("load_use.add.rd", 32'(id_ex_rd), 32'd4);

        // flush during a load-use hazard
        drive(32'h8C220000, 32'h0000_000C);
        tick();
        drive(32'h00452020, 32'h0000_000D);
        flush = 1'b1;
        #1;
        check("flush.pc_write",    32'(pc_write),    32'h1);
        check("flush.if_id_write", 32'(if_id_write), 32'h1);
        tick();
        flush = 1'b0;
        check_ctrl("flush.bubble", 2'b00, 3'b000, 4'b0000, 1'b0);

        // unknown opcode after the flush
        drive(32'hFC000000, 32'h0000_000E);
        tick();
        check_ctrl("unknown_op2", 2'b00, 3'b000, 4'b0000, 1'b0);

        // reset asserted mid-stall
        drive(32'h8C220000, 32'h0000_000F);
        tick();
        drive(32'h00452020, 32'h0000_0010);
        #1;
        check("mid_stall.pc_write", 32'(pc_write), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_stall_reset.pc_write",    32'(pc_write),    32'h1);
        check("mid_stall_reset.if_id_write", 32'(if_id_write), 32'h1);
        check_ctrl("mid_stall_reset", 2'b00, 3'b000, 4'b0000, 1'b0);
        check("mid_stall_reset.npc", id_ex_npc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
